// File: rtl/cpu_pkg.sv
// Shared CPU-front-end types and constants.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_HOLD,
    S_DRAIN,
    S_FAULT
  } fetch_state_t;
endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory req/ack, execute redirect, decode valid/ready.
interface inst_fetch_if;
  import cpu_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_pc_plus4;
  logic            fetch_fault;
  logic [XLEN-1:0] fetch_count;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc_plus4,
           fetch_fault, fetch_count,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc_plus4,
           fetch_fault, fetch_count,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/PCplus4.sv
// Purpose: next-sequential-PC adder, wraps modulo 2^XLEN.
// Latency: combinational.
// Backpressure: none.
module PCplus4
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);
  assign pc_plus4 = pc + 32'd4;
endmodule

// File: rtl/inst_fetch.sv
// Purpose: PC owner and single-outstanding instruction fetch with redirect/squash.
// Latency: ack -> inst_valid next cycle; handshake or redirect -> new request next cycle.
// Backpressure: holds inst in HOLD until inst_ready; no new request until handshake.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetch_if.master  bus
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] addr_q;
  logic            fault_pend;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic [XLEN-1:0] inst_pc_plus4_q;
  logic [XLEN-1:0] fetch_count_q;
  logic [XLEN-1:0] pc_plus4;
  logic            redir_misaligned;

  PCplus4 u_pcplus4 (
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  assign redir_misaligned = |bus.redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_RESET;
      pc              <= RESET_PC;
      addr_q          <= RESET_PC;
      fault_pend      <= 1'b0;
      inst_q          <= NOP_INST;
      inst_pc_q       <= RESET_PC;
      inst_pc_plus4_q <= RESET_PC + 32'd4;
      fetch_count_q   <= '0;
    end else begin
      case (state)
        S_RESET: begin
          if (bus.redirect_valid) begin
            pc         <= bus.redirect_pc;
            addr_q     <= bus.redirect_pc;
            fault_pend <= redir_misaligned;
            state      <= redir_misaligned ? S_FAULT : S_FETCH;
          end else begin
            addr_q <= pc;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (bus.redirect_valid) begin
            pc         <= bus.redirect_pc;
            fault_pend <= redir_misaligned;
            // Without an ack the request is still owed to memory, so it must drain.
            if (bus.imem_ack) begin
              addr_q <= bus.redirect_pc;
              state  <= redir_misaligned ? S_FAULT : S_FETCH;
            end else begin
              state <= S_DRAIN;
            end
          end else if (bus.imem_ack) begin
            inst_q          <= bus.imem_rdata;
            inst_pc_q       <= pc;
            inst_pc_plus4_q <= pc_plus4;
            state           <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.redirect_valid) begin
            pc         <= bus.redirect_pc;
            addr_q     <= bus.redirect_pc;
            fault_pend <= redir_misaligned;
            state      <= redir_misaligned ? S_FAULT : S_FETCH;
          end else if (bus.inst_ready) begin
            pc            <= pc_plus4;
            addr_q        <= pc_plus4;
            fetch_count_q <= fetch_count_q + 32'd1;
            state         <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (bus.redirect_valid) begin
            pc         <= bus.redirect_pc;
            fault_pend <= redir_misaligned;
            // An ack arriving alongside the redirect still retires the old request.
            if (bus.imem_ack) begin
              addr_q <= bus.redirect_pc;
              state  <= redir_misaligned ? S_FAULT : S_FETCH;
            end
          end else if (bus.imem_ack) begin
            addr_q <= pc;
            state  <= fault_pend ? S_FAULT : S_FETCH;
          end
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_RESET;
      endcase
    end
  end

  assign bus.imem_req      = (state == S_FETCH) || (state == S_DRAIN);
  assign bus.imem_addr     = addr_q;
  assign bus.inst_valid    = (state == S_HOLD);
  assign bus.inst          = inst_q;
  assign bus.inst_pc       = inst_pc_q;
  assign bus.inst_pc_plus4 = inst_pc_plus4_q;
  assign bus.fetch_fault   = (state == S_FAULT);
  assign bus.fetch_count   = fetch_count_q;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Multi-cycle instruction fetch stage sitting directly upstream of `decode`. Owns the program counter, issues one request at a time to instruction memory over a req/ack handshake, and holds the fetched word in an instruction register. Hands the word to decode over a valid/ready handshake. Accepts PC redirects from execute (branch/jump) and squashes any in-flight fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC loaded on reset; must be word-aligned.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; stable while `imem_req` is high.
- `imem_ack`  in  1  one-cycle pulse; `imem_rdata` is valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `redirect_valid`  in  1  one-cycle pulse; load a new PC.
- `redirect_pc`  in  32  redirect target.
- `inst_valid`  out  1  `inst`, `inst_pc` and `inst_pc_plus4` are valid.
- `inst_ready`  in  1  decode accepts the instruction.
- `inst`  out  32  instruction register.
- `inst_pc`  out  32  PC of `inst`.
- `inst_pc_plus4`  out  32  `inst_pc + 4`.
- `fetch_fault`  out  1  sticky; a misaligned redirect target was accepted.
- `fetch_count`  out  32  count of instructions handed to decode.

## Operation
- States: RESET, FETCH, HOLD, DRAIN, FAULT. All outputs are decoded from registers; there are no combinational input-to-output paths.
- RESET: entered for exactly one cycle after `rst` deasserts. `imem_req`=0. Goes to FETCH.
- FETCH: `imem_req`=1 and `imem_addr`=pc.
  - On `imem_ack`, capture `imem_rdata` into `inst`, set `inst_pc`=pc, and go to HOLD.
- HOLD: `inst_valid`=1 and `imem_req`=0.
  - On `inst_valid && inst_ready`: pc <= pc+4, `fetch_count` += 1, go to FETCH.
- Redirect has priority over all other events in every state except FAULT.
  - Latch pc <= `redirect_pc` and fault_pend <= (`redirect_pc[1:0]` != 0).
  - From HOLD or RESET, or from FETCH with `imem_ack` in the same cycle: the ack data is discarded and `inst_valid` drops. Next state is FAULT if fault_pend is set, else FETCH.
  - From FETCH without ack: go to DRAIN.
  - HOLD with `inst_ready` and `redirect_valid` in the same cycle: the handshake is void. `fetch_count` does not increment, and pc takes `redirect_pc`, not pc+4.
- DRAIN: `imem_req` stays 1 with `imem_addr` held at the old address, because the memory protocol forbids withdrawing a request. On `imem_ack`, discard the data and go to FETCH or FAULT per fault_pend. A further redirect in DRAIN overwrites pc and fault_pend (latest wins) and stays in DRAIN.
- FAULT: `fetch_fault`=1, `imem_req`=0, `inst_valid`=0. Redirects are ignored; only `rst` exits this state.
- Arithmetic: pc+4 and `fetch_count` wrap modulo 2^32 with no flag. `inst_pc_plus4` is registered together with `inst_pc`.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`, `inst_valid`=0.
  - `inst`=32'h0000_0013 (NOP), `inst_pc`=`RESET_PC`, `inst_pc_plus4`=`RESET_PC`+4.
  - `fetch_fault`=0, `fetch_count`=0, fault_pend=0.
- `rst` high in any state forces the reset values at the next edge; an outstanding memory request is abandoned.
- The first `imem_req` is asserted 2 cycles after the last `rst`-high edge (RESET cycle, then FETCH).
- Latencies:
  - `imem_ack` in cycle N: `inst_valid`=1 in cycle N+1.
  - Handshake in cycle M: `imem_req`=1 with the new address in cycle M+1.
  - Redirect in cycle R (non-DRAIN): `imem_req`=1 at `redirect_pc` in cycle R+1.
- Peak throughput is 1 instruction per 2 cycles, reached with zero-wait memory and `inst_ready` tied high.
- Memory may ack in the first cycle `imem_req` is high. An ack while `imem_req`=0 is ignored.

## Structure
- Shared package `cpu_pkg` holds:
  - `fetch_state_t` (the 5 states),
  - `NOP_INST` = 32'h0000_0013,
  - `XLEN` = 32.
- Use one sub-module: the existing `PCplus4` adder, instantiated once on the pc register. Its output drives both the sequential pc+4 and `inst_pc_plus4`.
- Registers: state, pc, fault_pend, inst, inst_pc, inst_pc_plus4, fetch_count.

## Test plan
- Reset, zero-wait memory, `inst_ready`=1:
  - `imem_addr` sequence 0x0, 0x4, 0x8.
  - `inst_valid` pulses every 2nd cycle.
  - `fetch_count`=3 after the third handshake.
- Memory wait of 3 cycles and `inst_ready` low for 4 cycles in HOLD:
  - `imem_addr` is stable during the wait.
  - `inst` and `inst_pc` are stable while `inst_valid`=1.
  - No new request is issued until the handshake.
- Redirect to 0x100 two cycles into a 5-cycle memory wait:
  - DRAIN holds the address at the old PC until the ack, and that data is discarded.
  - The next request is 0x100 and the next `inst_pc`=0x100.
- `inst_ready` and redirect to 0x40 in the same HOLD cycle:
  - `fetch_count` is unchanged.
  - Next `imem_addr`=0x40, not pc+4.
- Redirect to 0x102:
  - `fetch_fault`=1 next cycle and `imem_req` stays 0.
  - A later redirect to 0x200 is ignored.
  - `rst` clears the fault and fetch restarts at `RESET_PC`.
- `rst` asserted mid-DRAIN and in HOLD:
  - All outputs take their reset values next cycle.
  - The first request is at `RESET_PC`.
